// File: rtl/sfu_seq_ctrl_if.sv
// Handshake/bus bundle between the core FSM (master) and the SFU sequencer (slave).
//   start       : core -> seq, 1-cycle job request
//   ofifo_valid : OFIFO -> seq, a row is available
//   ofifo_rd    : seq -> OFIFO, pop
//   acc/acc_init/relu : seq -> SFU operation controls
//   pmem_ren/pmem_raddr/pmem_wen/pmem_waddr : seq -> psum memory
//   busy/done   : seq -> core status
interface sfu_seq_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              ofifo_valid;
  logic              ofifo_rd;
  logic              acc;
  logic              acc_init;
  logic              relu;
  logic              pmem_ren;
  logic [ADDR_W-1:0] pmem_raddr;
  logic              pmem_wen;
  logic [ADDR_W-1:0] pmem_waddr;
  logic              busy;
  logic              done;

  modport master (
    output start, ofifo_valid,
    input  ofifo_rd, acc, acc_init, relu, pmem_ren, pmem_raddr,
    input  pmem_wen, pmem_waddr, busy, done
  );

  modport slave (
    input  start, ofifo_valid,
    output ofifo_rd, acc, acc_init, relu, pmem_ren, pmem_raddr,
    output pmem_wen, pmem_waddr, busy, done
  );
endinterface

// File: rtl/sfu_seq_ctrl.sv
// SFU accumulate/ReLU sequencer.
// On start it drains N_OUT*N_KIJ OFIFO rows into psum memory with read-modify-write
// addressing, then runs one ReLU pass over every psum address and pulses done.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : sfu_seq_ctrl_if slave modport (start/ofifo handshake, SFU controls,
//           psum memory read/write port, busy/done status)
module sfu_seq_ctrl #(
  parameter int N_OUT  = 16,
  parameter int N_KIJ  = 9,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  sfu_seq_ctrl_if.slave  bus
);

  localparam int OUT_CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KIJ_CW = (N_KIJ > 1) ? $clog2(N_KIJ) : 1;
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(N_OUT - 1);
  localparam logic [KIJ_CW-1:0] KIJ_LAST = KIJ_CW'(N_KIJ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_ACC_DRAIN, S_RELU, S_RELU_DRAIN, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
  logic [KIJ_CW-1:0]   kij_cnt_q, kij_cnt_d;
  logic                acc_q, acc_d;
  logic                acc_init_q, acc_init_d;
  logic                relu_q, relu_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                done_q, done_d;

  logic                ofifo_rd_c;
  logic                ren_c;
  logic [ADDR_W-1:0]   raddr_c;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      out_cnt_q  <= '0;
      kij_cnt_q  <= '0;
      acc_q      <= 1'b0;
      acc_init_q <= 1'b0;
      relu_q     <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      kij_cnt_q  <= kij_cnt_d;
      acc_q      <= acc_d;
      acc_init_q <= acc_init_d;
      relu_q     <= relu_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      done_q     <= done_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    kij_cnt_d = kij_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_ACC;
          out_cnt_d = '0;
          kij_cnt_d = '0;
        end
      end
      S_ACC: begin
        // A stall (no valid row) freezes both counters.
        if (bus.ofifo_valid) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            // kij stays at its last value on exit so it never exceeds N_KIJ-1.
            if (kij_cnt_q == KIJ_LAST) state_d = S_ACC_DRAIN;
            else kij_cnt_d = kij_cnt_q + KIJ_CW'(1);
          end else begin
            out_cnt_d = out_cnt_q + OUT_CW'(1);
          end
        end
      end
      S_ACC_DRAIN: begin
        state_d   = S_RELU;
        out_cnt_d = '0;
      end
      S_RELU: begin
        if (out_cnt_q == OUT_LAST) begin
          state_d   = S_RELU_DRAIN;
          out_cnt_d = '0;
        end else begin
          out_cnt_d = out_cnt_q + OUT_CW'(1);
        end
      end
      S_RELU_DRAIN: state_d = S_FIN;
      S_FIN:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ofifo_rd_c = 1'b0;
    ren_c      = 1'b0;
    unique case (state_q)
      S_ACC: begin
        ofifo_rd_c = bus.ofifo_valid;
        ren_c      = bus.ofifo_valid;
      end
      S_RELU:  ren_c = 1'b1;
      default: ren_c = 1'b0;
    endcase
    raddr_c = ren_c ? ADDR_W'(out_cnt_q) : '0;

    // SFU controls are registered from the next state so they line up with the
    // state they belong to; the drain states keep them high while the SFU's
    // registered result for the final read is written back.
    acc_d      = (state_d == S_ACC) || (state_d == S_ACC_DRAIN);
    acc_init_d = (state_d == S_ACC) && (kij_cnt_d == '0);
    relu_d     = (state_d == S_RELU) || (state_d == S_RELU_DRAIN);

    // Write-back trails the read by one cycle, matching the SFU result register.
    wen_d   = ren_c;
    waddr_d = raddr_c;

    // done is registered off FIN, so it appears in the first IDLE cycle after FIN.
    done_d = (state_q == S_FIN);
  end

  assign bus.ofifo_rd   = ofifo_rd_c;
  assign bus.pmem_ren   = ren_c;
  assign bus.pmem_raddr = raddr_c;
  assign bus.acc        = acc_q;
  assign bus.acc_init   = acc_init_q;
  assign bus.relu       = relu_q;
  assign bus.pmem_wen   = wen_q;
  assign bus.pmem_waddr = waddr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
module tb_sfu_seq_ctrl;

  localparam int N_OUT = 4;
  localparam int N_KIJ = 2;
  localparam int NK    = N_OUT * N_KIJ;
  localparam int E_OUT = 16;
  localparam int E_KIJ = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sfu_seq_ctrl_if #(.ADDR_W(4)) bus ();
  sfu_seq_ctrl_if #(.ADDR_W(4)) ebus ();

  sfu_seq_ctrl #(.N_OUT(N_OUT), .N_KIJ(N_KIJ), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  sfu_seq_ctrl #(.N_OUT(E_OUT), .N_KIJ(E_KIJ), .ADDR_W(4)) edut (
    .clk(clk), .reset(reset), .bus(ebus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- behavioural model of the small instance ----------------
  // Job timeline: phase 0 idle, 1 = accumulating (m_n rows consumed so far),
  // 2 = after the last row (m_p cycles since it).
  int m_phase = 0;
  int m_n = 0;
  int m_p = 0;
  bit m_done = 0;
  bit m_ren_prev = 0;
  int m_raddr_prev = 0;

  typedef struct {
    bit rd, ren, acc, ainit, relu, busy, done;
    int raddr;
  } exp_t;

  function automatic exp_t exp_now();
    exp_t e;
    e = '{rd: 0, ren: 0, acc: 0, ainit: 0, relu: 0, busy: 0, done: 0, raddr: 0};
    if (m_phase == 0) begin
      e.done = m_done;
    end else if (m_phase == 1) begin
      e.busy  = 1;
      e.acc   = 1;
      e.ainit = (m_n / N_OUT) == 0;
      e.rd    = bus.ofifo_valid;
      e.ren   = bus.ofifo_valid;
      e.raddr = bus.ofifo_valid ? (m_n % N_OUT) : 0;
    end else begin
      e.busy = 1;
      if (m_p == 0) e.acc = 1;
      else if (m_p <= N_OUT) begin
        e.ren = 1; e.raddr = m_p - 1; e.relu = 1;
      end else if (m_p == N_OUT + 1) e.relu = 1;
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = 0; m_n = 0; m_p = 0; m_done = 0; m_ren_prev = 0; m_raddr_prev = 0;
    end else begin
      exp_t e;
      e = exp_now();
      m_ren_prev = e.ren;
      m_raddr_prev = e.raddr;
      m_done = 0;
      case (m_phase)
        0: if (bus.start) begin m_phase = 1; m_n = 0; end
        1: if (bus.ofifo_valid) begin
             m_n++;
             if (m_n == NK) begin m_phase = 2; m_p = 0; end
           end
        default: if (m_p == N_OUT + 2) begin m_phase = 0; m_done = 1; end
                 else m_p++;
      endcase
    end
  end

  // Per-cycle compare plus read/done logging for the literal checks.
  bit cmp_en = 0;
  int done_cnt = 0;
  int d_cyc = 0;
  int rq[$];
  int iq[$];

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      exp_t e;
      e = exp_now();
      check("ofifo_rd",   bus.ofifo_rd,   e.rd);
      check("pmem_ren",   bus.pmem_ren,   e.ren);
      check("pmem_raddr", bus.pmem_raddr, e.raddr);
      check("acc",        bus.acc,        e.acc);
      check("acc_init",   bus.acc_init,   e.ainit);
      check("relu",       bus.relu,       e.relu);
      check("busy",       bus.busy,       e.busy);
      check("done",       bus.done,       e.done);
      check("pmem_wen",   bus.pmem_wen,   m_ren_prev);
      check("pmem_waddr", bus.pmem_waddr, m_raddr_prev);
    end
    if (bus.ofifo_rd) begin
      rq.push_back(int'(bus.pmem_raddr));
      iq.push_back(int'(bus.acc_init));
    end
    if (bus.done) begin
      done_cnt++;
      d_cyc = cyc;
    end
  end

  // mode 0: valid held 1; 1: valid 1,0,1,0 from the start cycle;
  // 2: random valid and random start pulses; 3: valid 1 with extra starts in ACC/RELU/FIN.
  task automatic run_job(input int mode, input int exp_lat);
    int base;
    int s;
    base = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ofifo_valid = 1'b1;
    s = cyc;
    for (int k = 1; k < 400 && done_cnt == base; k++) begin
      @(posedge clk); #1;
      case (mode)
        1: begin bus.start = 1'b0; bus.ofifo_valid = (k % 2 == 0); end
        2: begin bus.start = ($urandom_range(0, 7) == 0); bus.ofifo_valid = $urandom_range(0, 1) == 1; end
        3: begin bus.start = (k == 3 || k == 12 || k == 15); bus.ofifo_valid = 1'b1; end
        default: begin bus.start = 1'b0; bus.ofifo_valid = 1'b1; end
      endcase
    end
    bus.start = 1'b0;
    if (done_cnt == base) check("done_timeout", 0, 1);
    else if (exp_lat >= 0) check("job_latency", d_cyc - s, exp_lat);
    for (int k = 0; k < 200 && bus.busy; k++) @(posedge clk);
    #1;
  endtask

  // ---------------- end-to-end model: SFU + psum memory ----------------
  int mem[E_OUT];
  int sfu_q = 0;
  int rows[$];
  int e_underflow = 0;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      int nv;
      int ra;
      nv = sfu_q;
      ra = int'(ebus.pmem_raddr);
      if (ebus.ofifo_rd) begin
        int v;
        if (rows.size() == 0) begin v = 0; e_underflow++; end
        else v = rows.pop_front();
        if (ebus.acc) nv = (ebus.acc_init ? 0 : mem[ra]) + v;
      end else if (ebus.pmem_ren && ebus.relu) begin
        nv = (mem[ra] < 0) ? 0 : mem[ra];
      end
      if (ebus.pmem_wen) mem[int'(ebus.pmem_waddr)] = sfu_q;
      sfu_q = nv;
    end
  end

  initial begin
    int exp_ra[8];
    int vals[E_KIJ][E_OUT];
    int sum;
    bit got_done;
    exp_ra = '{0, 1, 2, 3, 0, 1, 2, 3};
    bus.start = 1'b0;  bus.ofifo_valid = 1'b0;
    ebus.start = 1'b0; ebus.ofifo_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_wen", bus.pmem_wen, 0);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Test 1: valid held high
    rq.delete(); iq.delete();
    run_job(0, 16);
    check("t1_reads", rq.size(), 8);
    for (int i = 0; i < 8 && i < rq.size(); i++) begin
      check("t1_raddr", rq[i], exp_ra[i]);
      check("t1_acc_init", iq[i], (i < 4) ? 1 : 0);
    end

    // Test 2: valid toggling
    run_job(1, 24);

    // Test 3: extra starts while busy
    begin
      int base;
      base = done_cnt;
      run_job(3, 16);
      repeat (20) @(posedge clk);
      check("t3_done_pulses", done_cnt - base, 1);
    end

    // Test 4: async reset mid-ACC at kij=1, out=2
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ofifo_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("t4_raddr_before", bus.pmem_raddr, 2);
    check("t4_acc_init_before", bus.acc_init, 0);
    #2 reset = 1'b1;
    #1;
    check("t4_ofifo_rd", bus.ofifo_rd, 0);
    check("t4_ren", bus.pmem_ren, 0);
    check("t4_acc", bus.acc, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_wen", bus.pmem_wen, 0);
    @(negedge clk); #2 reset = 1'b0;
    rq.delete(); iq.delete();
    run_job(0, 16);
    check("t4_first_raddr", (rq.size() > 0) ? rq[0] : -1, 0);
    check("t4_first_init", (iq.size() > 0) ? iq[0] : -1, 1);

    // Random valid / random start pulses against the model
    for (int j = 0; j < 4; j++) run_job(2, -1);

    // Test 5: end-to-end, 16 outputs x 9 kernel positions
    for (int a = 0; a < E_OUT; a++) mem[a] = int'($urandom_range(0, 1000)) - 500;
    rows.delete();
    for (int k = 0; k < E_KIJ; k++)
      for (int a = 0; a < E_OUT; a++) begin
        vals[k][a] = int'($urandom_range(0, 200)) - 100;
        rows.push_back(vals[k][a]);
      end
    @(posedge clk); #1;
    ebus.start = 1'b1;
    ebus.ofifo_valid = 1'b0;
    got_done = 0;
    for (int k = 0; k < 2000 && !got_done; k++) begin
      @(posedge clk); #1;
      ebus.start = ($urandom_range(0, 15) == 0);
      ebus.ofifo_valid = $urandom_range(0, 1) == 1;
      if (ebus.done) got_done = 1;
    end
    ebus.start = 1'b0;
    ebus.ofifo_valid = 1'b0;
    check("e2e_done", got_done, 1);
    check("e2e_rows_left", rows.size(), 0);
    check("e2e_underflow", e_underflow, 0);
    for (int a = 0; a < E_OUT; a++) begin
      sum = 0;
      for (int k = 0; k < E_KIJ; k++) sum += vals[k][a];
      check("e2e_psum", mem[a], (sum < 0) ? 0 : sum);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
